// File: rtl/skin_detect.sv
// RGB to BT.601 YUV conversion with a U/V skin window test and causal horizontal smoothing.
// Every output, including the delay-matched RGB and control, appears exactly four clocks after its input.
module skin_detect #(
    parameter int unsigned U_MIN  = 77,
    parameter int unsigned U_MAX  = 127,
    parameter int unsigned V_MIN  = 133,
    parameter int unsigned V_MAX  = 173,
    parameter int unsigned WIN    = 5,
    parameter int unsigned THRESH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    input  logic [2:0] in_c,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic [7:0] out_y,
    output logic [7:0] out_u,
    output logic [7:0] out_v,
    output logic       out_skin,
    output logic [2:0] out_c
);

    localparam logic [7:0] U_LO = 8'(U_MIN);
    localparam logic [7:0] U_HI = 8'(U_MAX);
    localparam logic [7:0] V_LO = 8'(V_MIN);
    localparam logic [7:0] V_HI = 8'(V_MAX);
    localparam logic [3:0] THR  = 4'(THRESH);

    function automatic logic [7:0] clamp8(input logic signed [18:0] x);
        logic [7:0] res;
        if (x < 19'sd0) begin
            res = 8'd0;
        end else if (x > 19'sd255) begin
            res = 8'd255;
        end else begin
            res = x[7:0];
        end
        return res;
    endfunction

    logic signed [16:0] prod_d [0:8];
    logic signed [16:0] prod_q [0:8];
    logic [26:0]        dl_d   [0:3];
    logic [26:0]        dl_q   [0:3];
    logic [7:0]         y2_d, u2_d, v2_d, y2_q, u2_q, v2_q;
    logic [7:0]         y3_d, u3_d, v3_d, y3_q, u3_q, v3_q;
    logic [7:0]         y4_d, u4_d, v4_d, y4_q, u4_q, v4_q;
    logic               raw_d, raw_q;
    logic [WIN-1:0]     win_d, win_q;
    logic [WIN:0]       win_ext_s;
    logic [3:0]         cnt_d, cnt_q;
    logic               skin_d, skin_q;
    logic               de_s3;
    logic signed [16:0] r_s, g_s, b_s;
    logic signed [18:0] sum_y_s, sum_u_s, sum_v_s;

    // Stage 1 products and the RGB/control delay line.
    always_comb begin
        r_s = signed'({9'd0, in_r});
        g_s = signed'({9'd0, in_g});
        b_s = signed'({9'd0, in_b});
        prod_d[0] = 17'sd66 * r_s;
        prod_d[1] = 17'sd129 * g_s;
        prod_d[2] = 17'sd25 * b_s;
        prod_d[3] = -17'sd38 * r_s;
        prod_d[4] = -17'sd74 * g_s;
        prod_d[5] = 17'sd112 * b_s;
        prod_d[6] = 17'sd112 * r_s;
        prod_d[7] = -17'sd94 * g_s;
        prod_d[8] = -17'sd18 * b_s;
        dl_d[0] = {in_r, in_g, in_b, in_c};
        dl_d[1] = dl_q[0];
        dl_d[2] = dl_q[1];
        dl_d[3] = dl_q[2];
    end

    // Stage 2 rounding sums, floor shift, offset and clamp.
    always_comb begin
        sum_y_s = prod_q[0] + prod_q[1] + prod_q[2] + 19'sd128;
        sum_u_s = prod_q[3] + prod_q[4] + prod_q[5] + 19'sd128;
        sum_v_s = prod_q[6] + prod_q[7] + prod_q[8] + 19'sd128;
        y2_d = clamp8((sum_y_s >>> 8) + 19'sd16);
        u2_d = clamp8((sum_u_s >>> 8) + 19'sd128);
        v2_d = clamp8((sum_v_s >>> 8) + 19'sd128);
    end

    // Stage 3 raw classification; only pixels with de set can be skin.
    always_comb begin
        y3_d  = y2_q;
        u3_d  = u2_q;
        v3_d  = v2_q;
        raw_d = dl_q[1][0] & (u2_q >= U_LO) & (u2_q <= U_HI) & (v2_q >= V_LO) & (v2_q <= V_HI);
    end

    // Stage 4 sliding window; a de-low pixel clears the window instead of entering it.
    always_comb begin
        de_s3     = dl_q[2][0];
        y4_d      = y3_q;
        u4_d      = u3_q;
        v4_d      = v3_q;
        win_ext_s = {win_q, raw_q};
        if (de_s3) begin
            win_d  = win_ext_s[WIN-1:0];
            cnt_d  = cnt_q + {3'd0, raw_q} - {3'd0, win_q[WIN-1]};
            skin_d = (cnt_d >= THR);
        end else begin
            win_d  = '0;
            cnt_d  = 4'd0;
            skin_d = 1'b0;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) prod_q[i] <= 17'sd0;
            for (int i = 0; i < 4; i++) dl_q[i] <= 27'd0;
            y2_q <= 8'd0; u2_q <= 8'd0; v2_q <= 8'd0;
            y3_q <= 8'd0; u3_q <= 8'd0; v3_q <= 8'd0;
            y4_q <= 8'd0; u4_q <= 8'd0; v4_q <= 8'd0;
            raw_q  <= 1'b0;
            win_q  <= '0;
            cnt_q  <= 4'd0;
            skin_q <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
            for (int i = 0; i < 4; i++) dl_q[i] <= dl_d[i];
            y2_q <= y2_d; u2_q <= u2_d; v2_q <= v2_d;
            y3_q <= y3_d; u3_q <= u3_d; v3_q <= v3_d;
            y4_q <= y4_d; u4_q <= u4_d; v4_q <= v4_d;
            raw_q  <= raw_d;
            win_q  <= win_d;
            cnt_q  <= cnt_d;
            skin_q <= skin_d;
        end
    end

    assign out_r    = dl_q[3][26:19];
    assign out_g    = dl_q[3][18:11];
    assign out_b    = dl_q[3][10:3];
    assign out_c    = dl_q[3][2:0];
    assign out_y    = y4_q;
    assign out_u    = u4_q;
    assign out_v    = v4_q;
    assign out_skin = skin_q;

endmodule
